seq_wide_comparator: RTL

Sequential magnitude comparator for wide operands, built on the 16-bit cascadable compare slice. It latches two WIDTH-bit operands with a valid/ready handshake and walks them one 16-bit slice per cycle, most-significant slice first, carrying the running great/equal/less flags the same way the 16-bit comparator cascades. It stops on the first unequal slice and presents a registered one-hot result with its own valid/ready handshake. It sits upstream of sort/min-max logic that needs comparisons wider than one slice.

---
 rtl/seq_wide_comparator.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/seq_wide_comparator.sv
// -----------------------------------------------------------------------------
// seq_wide_comparator
//
// Sequential magnitude comparator for WIDTH-bit operands. A request is latched
// through a valid/ready handshake, then the operands are walked one 16-bit
// slice per cycle, most-significant slice first, through a cascadable 16-bit
// compare slice. The walk stops on the first unequal slice. If every slice is
// equal, the result comes from the normalised lower-significance cascade flags
// that were latched with the request. The one-hot result is registered and
// offered through its own valid/ready handshake.
//
// Ports
//   clk                     clock, rising edge
//   rst                     synchronous active-high reset
//   start_valid/start_ready request handshake (start_ready only in IDLE)
//   a, b                    WIDTH-bit operands, sampled on the accept edge
//   signed_mode             1: two's complement, 0: unsigned (sampled on accept)
//   greatin/equalin/lessin  lower-significance cascade inputs (sampled on accept)
//   res_valid/res_ready     result handshake
//   great/equal/less        registered one-hot result, held between results
// -----------------------------------------------------------------------------

// 16-bit cascadable compare slice. When the slice operands are equal, the
// cascade inputs pass straight through to the outputs. invert_msb_i flips
// bit 15 of both operands, which turns an unsigned compare into a
// two's-complement compare for the most-significant slice.
module cmp16_slice (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        invert_msb_i,
  input  logic        great_i,
  input  logic        equal_i,
  input  logic        less_i,
  output logic        great_o,
  output logic        equal_o,
  output logic        less_o
);

  logic [15:0] a_m;
  logic [15:0] b_m;
  logic        gt;
  logic        lt;

  assign a_m = {a_i[15] ^ invert_msb_i, a_i[14:0]};
  assign b_m = {b_i[15] ^ invert_msb_i, b_i[14:0]};
  assign gt  = (a_m > b_m);
  assign lt  = (a_m < b_m);

  assign great_o = gt | (~gt & ~lt & great_i);
  assign less_o  = lt | (~gt & ~lt & less_i);
  assign equal_o = ~gt & ~lt & equal_i;

endmodule

module seq_wide_comparator #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             greatin,
  input  logic             equalin,
  input  logic             lessin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             great,
  output logic             equal,
  output logic             less
);

  localparam int unsigned NSLICE = WIDTH / 16;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                      state_q, state_d;
  logic [NSLICE-1:0][15:0]     a_q, a_d;
  logic [NSLICE-1:0][15:0]     b_q, b_d;
  logic                        signed_q, signed_d;
  logic [KW-1:0]               k_q, k_d;
  // Normalised cascade flags captured at accept time.
  logic                        cg_q, cg_d;
  logic                        ce_q, ce_d;
  logic                        cl_q, cl_d;
  // Registered result.
  logic                        great_q, great_d;
  logic                        equal_q, equal_d;
  logic                        less_q, less_d;

  // equalin carries no information once greatin and lessin are known: the
  // normalised result is equal whenever neither of them is set.
  logic unused_equalin;
  assign unused_equalin = equalin;

  // ---------------------------------------------------------------------------
  // Slice datapath
  // ---------------------------------------------------------------------------
  logic at_lsb;
  logic invert_msb;
  logic s_great_in, s_equal_in, s_less_in;
  logic s_great, s_equal, s_less;

  assign at_lsb     = (k_q == '0);
  assign invert_msb = signed_q && (k_q == LAST_K);

  // Above slice 0 the slice is fed a neutral "equal" cascade so that its
  // equal output simply means "this slice matched, keep walking". At slice 0
  // the latched cascade flags decide the outcome of an all-equal walk.
  assign s_great_in = at_lsb ? cg_q : 1'b0;
  assign s_equal_in = at_lsb ? ce_q : 1'b1;
  assign s_less_in  = at_lsb ? cl_q : 1'b0;

  cmp16_slice u_slice (
    .a_i          (a_q[k_q]),
    .b_i          (b_q[k_q]),
    .invert_msb_i (invert_msb),
    .great_i      (s_great_in),
    .equal_i      (s_equal_in),
    .less_i       (s_less_in),
    .great_o      (s_great),
    .equal_o      (s_equal),
    .less_o       (s_less)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    k_d      = k_q;
    cg_d     = cg_q;
    ce_d     = ce_q;
    cl_d     = cl_q;
    great_d  = great_q;
    equal_d  = equal_q;
    less_d   = less_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d      = a;
          b_d      = b;
          signed_d = signed_mode;
          k_d      = LAST_K;
          // Priority: greatin wins, then lessin, otherwise equal (this
          // includes the all-zero cascade).
          cg_d     = greatin;
          cl_d     = ~greatin & lessin;
          ce_d     = ~greatin & ~lessin;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        if (at_lsb || !s_equal) begin
          great_d = s_great;
          equal_d = s_equal;
          less_d  = s_less;
          state_d = ST_DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      great_q <= 1'b0;
      equal_q <= 1'b0;
      less_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      great_q <= great_d;
      equal_q <= equal_d;
      less_q  <= less_d;
    end
  end

  // NOTE: the operand, mode, index and cascade registers are deliberately left
  // without reset; they are always written on accept before RUN reads them.
  always_ff @(posedge clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    signed_q <= signed_d;
    k_q      <= k_d;
    cg_q     <= cg_d;
    ce_q     <= ce_d;
    cl_q     <= cl_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Both handshake outputs are masked by rst so neither is seen while reset is
  // held, even in the first reset cycle before the state register clears.
  assign start_ready = (state_q == ST_IDLE) & ~rst;
  assign res_valid   = (state_q == ST_DONE) & ~rst;
  assign great       = great_q;
  assign equal       = equal_q;
  assign less        = less_q;

endmodule
